// File: rtl/stream_demux.sv
// stream_demux: steers one valid/ready stream to one of N channels by one-hot select, through a single-entry output register.
// Define STREAM_DEMUX_SEL_CHECK_EN to drop zero/multi-hot selects, pulse err_o and count drops in drop_cnt_o.
module stream_demux #(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [W-1:0]     in_data_i,
  input  logic [N-1:0]     in_sel_i,
  output logic             in_ready_o,
  output logic [N-1:0]     out_valid_o,
  output logic [W-1:0]     out_data_o,
  input  logic [N-1:0]     out_ready_i,
  output logic             err_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic [N-1:0] sel_q, sel_d;
  logic         drn;
  logic         acc;
  logic         load;

  // Only the selected channel's ready matters; a stalled destination blocks the input.
  assign drn         = full_q & |(sel_q & out_ready_i);
  assign in_ready_o  = ~full_q | drn;
  assign acc         = in_valid_i & in_ready_o;
  assign out_valid_o = {N{full_q}} & sel_q;
  assign out_data_o  = data_q;

`ifdef STREAM_DEMUX_SEL_CHECK_EN
  logic             legal;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves nothing.
  assign legal = (in_sel_i != '0) && ((in_sel_i & (in_sel_i - N'(1))) == '0);
  assign load  = acc & legal;

  always_comb begin
    err_d = 1'b0;
    cnt_d = cnt_q;
    if (acc && !legal) begin
      err_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_o      = err_q;
  assign drop_cnt_o = cnt_q;
`else
  assign load       = acc;
  assign err_o      = 1'b0;
  assign drop_cnt_o = '0;

  sel_onehot_a: assert property (@(posedge clk) disable iff (rst) in_valid_i |-> $onehot(in_sel_i));
`endif

  // A legal load on a draining cycle keeps full_q set: back-to-back with no bubble.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    sel_d  = sel_q;
    if (drn) full_d = 1'b0;
    if (load) begin
      full_d = 1'b1;
      data_d = in_data_i;
      sel_d  = in_sel_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Randomized + directed bench for stream_demux with a queue-based reference model and a decoupled output scoreboard.
// Illegal-select stimulus is only issued when STREAM_DEMUX_SEL_CHECK_EN is defined.
module tb_stream_demux;
  localparam int N     = 4;
  localparam int W     = 32;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic [N-1:0] sel;
    logic [W-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid_i = 1'b0;
  logic [W-1:0]     in_data_i = '0;
  logic [N-1:0]     in_sel_i = 4'b0001;
  logic             in_ready_o;
  logic [N-1:0]     out_valid_o;
  logic [W-1:0]     out_data_o;
  logic [N-1:0]     out_ready_i = '0;
  logic             err_o;
  logic [CNT_W-1:0] drop_cnt_o;

  stream_demux #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_sel_i   (in_sel_i),
    .in_ready_o (in_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_ready_i(out_ready_i),
    .err_o      (err_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int err_pulses = 0;
  bit chk_en = 1'b0;

  // Reference model: the output register is a queue of at most one beat.
  beat_t m_held[$];
  beat_t exp_q[$];
  logic [W-1:0] m_last = '0;
  logic         m_err = 1'b0;
  int           m_cnt = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [N-1:0] s);
`ifdef STREAM_DEMUX_SEL_CHECK_EN
    return $countones(s) == 1;
`else
    return s == s;
`endif
  endfunction

  // Model: compare cycle outputs, then advance model state for the coming edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_vld;
    bit           exp_rdy;
    bit           drain;
    beat_t        b;
    if (chk_en) begin
      exp_vld = (m_held.size() != 0) ? m_held[0].sel : '0;
      exp_rdy = (m_held.size() == 0) || ((m_held[0].sel & out_ready_i) != '0);
      chk("in_ready", W'(in_ready_o), W'(exp_rdy));
      chk("out_valid", W'(out_valid_o), W'(exp_vld));
      chk("out_data", out_data_o, m_last);
      chk("err", W'(err_o), W'(m_err));
      chk("drop_cnt", W'(drop_cnt_o), W'(m_cnt));
      if (err_o) err_pulses++;
      if (rst) begin
        m_held.delete();
        exp_q.delete();
        m_last = '0;
        m_err  = 1'b0;
        m_cnt  = 0;
      end else begin
        drain = (m_held.size() != 0) && ((m_held[0].sel & out_ready_i) != '0);
        if (drain) void'(m_held.pop_front());
        m_err = 1'b0;
        if (in_valid_i && exp_rdy) begin
          if (is_legal(in_sel_i)) begin
            b.sel  = in_sel_i;
            b.data = in_data_i;
            m_held.push_back(b);
            exp_q.push_back(b);
            m_last = in_data_i;
          end else begin
            m_err = 1'b1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every output handshake pops the oldest expected beat.
  always @(negedge clk) begin
    beat_t b;
    if (chk_en && !rst) begin
      if ($countones(out_valid_o) > 1) chk("valid_onehot", W'(out_valid_o), W'(0));
      if ((out_valid_o & out_ready_i) != '0) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got sel %b data %h expected no beat", out_valid_o, out_data_o);
        end else begin
          b = exp_q.pop_front();
          chk("sb_sel", W'(out_valid_o), W'(b.sel));
          chk("sb_data", out_data_o, b.data);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic [N-1:0] s, input logic [N-1:0] r);
    in_valid_i  = v;
    in_data_i   = d;
    in_sel_i    = s;
    out_ready_i = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, '0, 4'b0001, '0);
    rst = 1'b0;
  endtask

  initial begin
    int h0;
    int e0;
    logic [N-1:0] s;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset();
    chk("rst_ready", W'(in_ready_o), W'(1));
    chk("rst_valid", W'(out_valid_o), W'(0));

    // Single beat to ch2
    cyc(1'b1, 32'hA5A5_0001, 4'b0100, 4'b0100);
    chk("t1_valid", W'(out_valid_o), W'(4'b0100));
    chk("t1_data", out_data_o, 32'hA5A5_0001);
    chk("t1_ready", W'(in_ready_o), W'(1));
    cyc(1'b0, '0, 4'b0001, 4'b1111);

    // Back-to-back round robin, no bubbles
    h0 = hs_cnt;
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h1000 + i, 4'b0001 << (i % 4), 4'b1111);
    cyc(1'b0, '0, 4'b0001, 4'b1111);
    chk("b2b_beats", W'(hs_cnt - h0), W'(8));

    // Stalled ch2 with ch0 ready: head-of-line hold
    cyc(1'b1, 32'hC3C3_0002, 4'b0100, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'hC3C3_0003, 4'b0001, 4'b0001);
      chk("stall_ready", W'(in_ready_o), W'(0));
      chk("stall_data", out_data_o, 32'hC3C3_0002);
    end
    cyc(1'b1, 32'hC3C3_0003, 4'b0001, 4'b0101);
    chk("release_valid", W'(out_valid_o), W'(4'b0001));
    chk("release_data", out_data_o, 32'hC3C3_0003);
    cyc(1'b0, '0, 4'b0001, 4'b1111);

`ifdef STREAM_DEMUX_SEL_CHECK_EN
    cyc(1'b1, 32'hDEAD_0000, 4'b0000, 4'b1111);
    chk("ill0_err", W'(err_o), W'(1));
    chk("ill0_cnt", W'(drop_cnt_o), W'(1));
    cyc(1'b1, 32'hDEAD_0110, 4'b0110, 4'b1111);
    chk("ill1_err", W'(err_o), W'(1));
    chk("ill1_cnt", W'(drop_cnt_o), W'(2));
    chk("ill1_valid", W'(out_valid_o), W'(0));
    cyc(1'b1, 32'hBEEF_0010, 4'b0010, 4'b1111);
    chk("legal_err", W'(err_o), W'(0));
    chk("legal_valid", W'(out_valid_o), W'(4'b0010));
    do_reset();
    e0 = err_pulses;
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h5A00 + i, (i % 2) ? 4'b1111 : 4'b0000, 4'b1111);
    cyc(1'b0, '0, 4'b0001, 4'b1111);
    chk("sat_cnt", W'(drop_cnt_o), W'(3));
    chk("sat_pulses", W'(err_pulses - e0), W'(5));
`endif

    // Reset while a beat is held on ch1
    cyc(1'b1, 32'h7777_0001, 4'b0010, 4'b0000);
    cyc(1'b0, '0, 4'b0001, 4'b0000);
    rst = 1'b1;
    cyc(1'b0, '0, 4'b0001, 4'b0000);
    rst = 1'b0;
    chk("mid_rst_valid", W'(out_valid_o), W'(0));
    chk("mid_rst_data", out_data_o, W'(0));
    chk("mid_rst_cnt", W'(drop_cnt_o), W'(0));
    chk("mid_rst_ready", W'(in_ready_o), W'(1));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s = 4'b0001 << $urandom_range(0, 3);
`ifdef STREAM_DEMUX_SEL_CHECK_EN
      if ($urandom_range(0, 6) == 0) begin
        s = 4'($urandom);
        if ($countones(s) == 1) s = 4'b0000;
      end
`endif
      cyc(($urandom_range(0, 3) != 0), W'($urandom), s, 4'($urandom | $urandom));
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 4'b0001, 4'b1111);
    chk("sb_empty", W'(exp_q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered one-hot stream demultiplexer: steers a single valid/ready input stream to exactly one of N output channels selected by a one-hot select carried with each beat. It is the fan-out counterpart to the common one-hot AND-OR mux and sits wherever one producer feeds N consumers (request routing, per-port dispatch). It provides a single-entry output register with full throughput, optional illegal-select detection, and a saturating drop counter.

## Interface
- N, 4, number of output channels (≥2)
- W, 32, data width (≥1)
- CNT_W, 8, drop counter width (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid_i  in  1  input beat valid
- in_data_i  in  W  input payload
- in_sel_i  in  N  one-hot destination select, qualified by in_valid_i
- in_ready_o  out  1  input may be accepted this cycle
- out_valid_o  out  N  per-channel valid; at most one bit set
- out_data_o  out  W  payload shared by all channels, qualified per channel by out_valid_o
- out_ready_i  in  N  per-channel ready
- err_o  out  1  one-cycle pulse: an illegal select was accepted and dropped
- drop_cnt_o  out  CNT_W  saturating count of dropped beats

## Operation
- State: full_q, data_q[W], sel_q[N], err_q, cnt_q[CNT_W].
- Accept: acc = in_valid_i & in_ready_o. Drain: drn = full_q & |(sel_q & out_ready_i).
- in_ready_o = ~full_q | drn (combinational from out_ready_i; no combinational in_valid_i→in_ready_o path).
- out_valid_o = {N{full_q}} & sel_q; out_data_o = data_q.
- Legal select: exactly one bit of in_sel_i set (popcount == 1).
- On acc with legal select: data_q←in_data_i, sel_q←in_sel_i, full_q←1.
- On acc with illegal select (zero or multi-hot, check enabled): beat consumed, not forwarded; full_q←(full_q & ~drn); data_q/sel_q unchanged; err_q←1; cnt_q←cnt_q+1 unless all-ones.
- On drn without legal acc: full_q←0. Simultaneous drn and legal acc: full_q stays 1, register reloads (back-to-back, no bubble).
- err_q clears to 0 in any cycle without an illegal accept.
- Once out_valid_o[j] is asserted, data_q and sel_q hold until that channel's out_ready_i is sampled high; in_valid_i may drop freely on input side (no input-side stability required after acceptance).
- Channels other than the selected one do not affect progress; a stalled destination blocks the whole input (head-of-line, intended).

## Timing
- Reset (rst=1 at edge): full_q=0, data_q=0, sel_q=0, err_q=0, cnt_q=0; thus out_valid_o=0, out_data_o=0, err_o=0, drop_cnt_o=0, in_ready_o=1 the cycle after reset. Reset mid-transfer discards any held beat.
- Latency: beat accepted at edge k appears on out_valid_o/out_data_o in cycle k+1.
- Throughput: one beat per cycle when destination ready stays high.
- err_o asserts in cycle k+1 for an illegal beat accepted at edge k, for one cycle; drop_cnt_o updates the same cycle.
- Counter saturation: at 2^CNT_W−1 further drops leave it unchanged; err_o still pulses.

## Configuration
- STREAM_DEMUX_SEL_CHECK_EN defined: legality check, drop behaviour, err_o and drop_cnt_o as above.
- Not defined: no popcount logic; in_sel_i must be one-hot (protocol requirement, guarded only by simulation assertion); all accepted beats load the register; err_o and drop_cnt_o tied to 0; behaviour for non-one-hot select is undefined.

## Test plan
- Reset then single beat data=0xA5A5_0001, sel=4'b0100, out_ready_i=4'b0100 → cycle k+1 out_valid_o=4'b0100, out_data_o=0xA5A5_0001; in_ready_o stays 1.
- Back-to-back 8 beats round-robin sel 0001→1000, all out_ready_i=1 → one beat per cycle on matching channel, data in order, no bubbles.
- Beat to ch2 with out_ready_i[2]=0 for 5 cycles, out_ready_i[0]=1 → out_valid_o=4'b0100 held with stable data, in_ready_o=0; release ready → drained, next beat accepted same cycle.
- (CHECK_EN) sel=4'b0000 then sel=4'b0110 → neither forwarded, err_o pulses each, drop_cnt_o=1 then 2; following legal beat forwarded normally.
- (CHECK_EN, CNT_W=2) 5 illegal beats → drop_cnt_o saturates at 3, err_o pulses 5 times.
- Assert rst while beat held on ch1 with out_ready_i=0 → next cycle out_valid_o=0, out_data_o=0, drop_cnt_o=0, in_ready_o=1.
